// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cfg
// Brief    : Parametrised UART receiver (5..9 data bits, none/even/odd parity,
//            1 or 2 stop bits) with one-entry valid/ready holding register.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic                 i_RX_Serial,
    output logic                 o_RX_Valid,
    input  logic                 i_RX_Ready,
    output logic [DATA_BITS-1:0] o_RX_Data,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Overrun
);

    localparam int              c_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int              c_IDX_W     = $clog2(DATA_BITS);
    localparam logic [c_CNT_W-1:0] c_HALF      = c_CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_DATA_LAST = c_IDX_W'(DATA_BITS - 1);
    localparam logic            c_STOP_LAST = 1'(STOP_BITS - 1);
    localparam bit              c_HAS_PAR   = (PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic                 r_rx_meta;
    logic                 r_rx_s;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic [c_IDX_W-1:0]   w_bit_idx_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 r_pbit;
    logic                 w_pbit_nxt;
    logic                 r_stop_idx;
    logic                 w_stop_idx_nxt;
    logic                 r_stop_err;
    logic                 w_stop_err_nxt;
    logic                 r_stop0;
    logic                 w_stop0_nxt;
    logic                 w_done;
    logic                 w_bit_tick;

    logic                 w_par_xor;
    logic                 w_par_err;
    logic                 w_break;

    logic                 r_valid;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_par_err;
    logic                 r_frame_err;
    logic                 r_break;
    logic                 r_overrun;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_RX_Serial;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_pbit     <= 1'b0;
            r_stop_idx <= 1'b0;
            r_stop_err <= 1'b0;
            r_stop0    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_pbit     <= w_pbit_nxt;
            r_stop_idx <= w_stop_idx_nxt;
            r_stop_err <= w_stop_err_nxt;
            r_stop0    <= w_stop0_nxt;
        end
    end

    assign w_bit_tick = (r_cnt == c_BIT_LAST);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_bit_idx_nxt  = r_bit_idx;
        w_shift_nxt    = r_shift;
        w_pbit_nxt     = r_pbit;
        w_stop_idx_nxt = r_stop_idx;
        w_stop_err_nxt = r_stop_err;
        w_stop0_nxt    = r_stop0;
        w_done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt      = '0;
                w_bit_idx_nxt  = '0;
                w_stop_idx_nxt = 1'b0;
                w_stop_err_nxt = 1'b0;
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_cnt == c_HALF) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_tick) begin
                    w_cnt_nxt = '0;
                    // LSB arrives first, so shifting in at the top leaves it at bit 0.
                    w_shift_nxt = {r_rx_s, r_shift[DATA_BITS-1:1]};
                    if (r_bit_idx == c_DATA_LAST) begin
                        w_state_nxt = c_HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_PARITY: begin
                if (w_bit_tick) begin
                    w_cnt_nxt   = '0;
                    w_pbit_nxt  = r_rx_s;
                    w_state_nxt = S_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_tick) begin
                    w_cnt_nxt      = '0;
                    w_stop_err_nxt = r_stop_err | ~r_rx_s;
                    if (r_stop_idx == 1'b0) begin
                        w_stop0_nxt = r_rx_s;
                    end
                    // Return to IDLE mid stop bit so a back-to-back start edge is caught.
                    if (r_stop_idx == c_STOP_LAST) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_stop_idx_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_par_xor = (^r_shift) ^ r_pbit;
    assign w_par_err = (PARITY == 1) ? w_par_xor :
                       (PARITY == 2) ? ~w_par_xor : 1'b0;
    assign w_break   = (r_shift == '0) && (!c_HAS_PAR || !r_pbit) && !w_stop0_nxt;

    // Holding register: a completing frame wins over a same-edge clear.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_break     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_done) begin
                if (!r_valid || i_RX_Ready) begin
                    r_valid     <= 1'b1;
                    r_data      <= r_shift;
                    r_par_err   <= w_par_err;
                    r_frame_err <= w_stop_err_nxt;
                    r_break     <= w_break;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && i_RX_Ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_RX_Valid   = r_valid;
    assign o_RX_Data    = r_data;
    assign o_Parity_Err = r_par_err;
    assign o_Frame_Err  = r_frame_err;
    assign o_Break      = r_break;
    assign o_Overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_cfg
// Brief    : Scoreboard bench for uart_rx_cfg in 8N1, 7E2 and 9O1 builds.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_cfg;

    localparam int C       = 16;
    localparam int H       = (C - 1) / 2;
    localparam int LAT_8N1 = 3 + H + (8 + 0 + 1) * C;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       rx_a, rx_b, rx_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic       vld_a, vld_b, vld_c;
    logic [7:0] dat_a;
    logic [6:0] dat_b;
    logic [8:0] dat_c;
    logic       pe_a, fe_a, bk_a, ov_a;
    logic       pe_b, fe_b, bk_b, ov_b;
    logic       pe_c, fe_c, bk_c, ov_c;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic vprev[3];
    logic rdy_e[3];
    int   ovr_run[3];
    int   ovr_cnt[3];
    int   ovr_edge_a;
    int   start_a;
    bit   lat_arm;
    int   s1;
    int   tgt;
    logic p;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .i_Clock(clk), .i_Rst_L(rst_l), .i_RX_Serial(rx_a), .o_RX_Valid(vld_a),
        .i_RX_Ready(rdy_a), .o_RX_Data(dat_a), .o_Parity_Err(pe_a),
        .o_Frame_Err(fe_a), .o_Break(bk_a), .o_Overrun(ov_a));

    uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7e2 (
        .i_Clock(clk), .i_Rst_L(rst_l), .i_RX_Serial(rx_b), .o_RX_Valid(vld_b),
        .i_RX_Ready(rdy_b), .o_RX_Data(dat_b), .o_Parity_Err(pe_b),
        .o_Frame_Err(fe_b), .o_Break(bk_b), .o_Overrun(ov_b));

    uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(9), .PARITY(2), .STOP_BITS(1)) u_9o1 (
        .i_Clock(clk), .i_Rst_L(rst_l), .i_RX_Serial(rx_c), .o_RX_Valid(vld_c),
        .i_RX_Ready(rdy_c), .o_RX_Data(dat_c), .o_Parity_Err(pe_c),
        .o_Frame_Err(fe_c), .o_Break(bk_c), .o_Overrun(ov_c));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic par_bit(input int mode, input logic [8:0] d, input int nbits);
        logic x;
        x = 1'b0;
        for (int i = 0; i < nbits; i++) x = x ^ d[i];
        return (mode == 2) ? ~x : x;
    endfunction

    task automatic expect_frame(input int id, input logic [8:0] d, input int mode, input int nbits,
                                input logic pbit, input logic stop0, input logic stop1);
        exp_t e;
        logic x;
        x = par_bit(1, d, nbits) ^ pbit;
        e.data = d;
        e.perr = (mode == 1) ? x : (mode == 2) ? ~x : 1'b0;
        e.ferr = !stop0 || !stop1;
        e.brk  = (d == 9'h0) && (mode == 0 || !pbit) && !stop0;
        case (id)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    task automatic set_line(input int id, input logic v);
        case (id)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic send_frame(input int id, input logic [8:0] data, input int nbits, input bit has_par,
                              input logic pbit, input int nstop, input logic stop0);
        logic [12:0] bits;
        int          n;
        bits    = '0;
        n       = 1;
        for (int i = 0; i < nbits; i++) begin
            bits[n] = data[i];
            n++;
        end
        if (has_par) begin
            bits[n] = pbit;
            n++;
        end
        bits[n] = stop0;
        n++;
        if (nstop == 2) begin
            bits[n] = 1'b1;
            n++;
        end
        for (int i = 0; i < n; i++) begin
            set_line(id, bits[i]);
            repeat (C) @(negedge clk);
        end
        set_line(id, 1'b1);
    endtask

    // A frame load is a valid-high sample that was not a plain hold.
    task automatic mon(input int id, input logic v, input logic r, input logic [8:0] d,
                       input logic pe, input logic fe, input logic bk, input logic ov);
        exp_t e;
        int   qs;
        if (v && (!vprev[id] || r)) begin
            qs = (id == 0) ? q_a.size() : (id == 1) ? q_b.size() : q_c.size();
            if (qs == 0) begin
                check_val($sformatf("pending_frames_%0d", id), qs, 1);
            end else begin
                case (id)
                    0:       e = q_a.pop_front();
                    1:       e = q_b.pop_front();
                    default: e = q_c.pop_front();
                endcase
                check_val($sformatf("data_%0d", id), d, e.data);
                check_val($sformatf("perr_%0d", id), pe, e.perr);
                check_val($sformatf("ferr_%0d", id), fe, e.ferr);
                check_val($sformatf("break_%0d", id), bk, e.brk);
                if (id == 0 && lat_arm) begin
                    check_val("latency_8n1", cyc - start_a, LAT_8N1);
                    lat_arm = 1'b0;
                end
            end
        end
        vprev[id] = v;
        if (ov) begin
            if (ovr_run[id] == 0) begin
                ovr_cnt[id]++;
                if (id == 0) ovr_edge_a = cyc;
            end
            ovr_run[id]++;
        end else if (ovr_run[id] != 0) begin
            check_val($sformatf("overrun_width_%0d", id), ovr_run[id], 1);
            ovr_run[id] = 0;
        end
    endtask

    always @(posedge clk) begin
        cyc      = cyc + 1;
        rdy_e[0] = rdy_a;
        rdy_e[1] = rdy_b;
        rdy_e[2] = rdy_c;
        #1;
        mon(0, vld_a, rdy_e[0], {1'b0, dat_a}, pe_a, fe_a, bk_a, ov_a);
        mon(1, vld_b, rdy_e[1], {2'b0, dat_b}, pe_b, fe_b, bk_b, ov_b);
        mon(2, vld_c, rdy_e[2], dat_c, pe_c, fe_c, bk_c, ov_c);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            vprev[i]   = 1'b0;
            ovr_run[i] = 0;
            ovr_cnt[i] = 0;
        end
        ovr_edge_a = 0;
        lat_arm    = 1'b0;
        rst_l = 1'b0;
        rx_a  = 1'b1; rx_b  = 1'b1; rx_c  = 1'b1;
        rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_valid_a", vld_a, 0);
        check_val("rst_data_a", dat_a, 0);
        check_val("rst_perr_a", pe_a, 0);
        check_val("rst_ferr_a", fe_a, 0);
        check_val("rst_break_a", bk_a, 0);
        check_val("rst_ovr_a", ov_a, 0);
        check_val("rst_valid_b", vld_b, 0);
        check_val("rst_valid_c", vld_c, 0);
        rst_l = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1 0xA5, ready low: latency, then hold until a single ready pulse
        expect_frame(0, 9'hA5, 0, 8, 1'b0, 1'b1, 1'b1);
        start_a = cyc + 1;
        lat_arm = 1'b1;
        send_frame(0, 9'hA5, 8, 0, 1'b0, 1, 1'b1);
        repeat (20) @(negedge clk);
        check_val("hold_valid_a", vld_a, 1);
        check_val("hold_data_a", dat_a, 8'hA5);
        rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
        check_val("accept_clears_a", vld_a, 0);

        // 7E2 0x35, correct then wrong parity bit
        rdy_b = 1'b1;
        p = par_bit(1, 9'h35, 7);
        expect_frame(1, 9'h35, 1, 7, p, 1'b1, 1'b1);
        send_frame(1, 9'h35, 7, 1, p, 2, 1'b1);
        repeat (5) @(negedge clk);
        expect_frame(1, 9'h35, 1, 7, ~p, 1'b1, 1'b1);
        send_frame(1, 9'h35, 7, 1, ~p, 2, 1'b1);
        repeat (5) @(negedge clk);

        // 8N1 framing error, then 12 bit times of break
        rdy_a = 1'b1;
        expect_frame(0, 9'h3C, 0, 8, 1'b0, 1'b0, 1'b1);
        send_frame(0, 9'h3C, 8, 0, 1'b0, 1, 1'b0);
        repeat (40) @(negedge clk);
        expect_frame(0, 9'h000, 0, 8, 1'b0, 1'b0, 1'b1);
        // The still-low line restarts a frame; its bit 0 lands before the release, the rest after.
        expect_frame(0, 9'h0FE, 0, 8, 1'b0, 1'b1, 1'b1);
        set_line(0, 1'b0);
        repeat (12 * C) @(negedge clk);
        set_line(0, 1'b1);
        repeat (160) @(negedge clk);

        // 3-cycle glitch is a false start; next frame still received
        set_line(0, 1'b0);
        repeat (3) @(negedge clk);
        set_line(0, 1'b1);
        repeat (40) @(negedge clk);
        check_val("glitch_no_valid", vld_a, 0);
        expect_frame(0, 9'h5A, 0, 8, 1'b0, 1'b1, 1'b1);
        send_frame(0, 9'h5A, 8, 0, 1'b0, 1, 1'b1);
        repeat (5) @(negedge clk);

        // Back-to-back with ready low: second frame dropped
        rdy_a = 1'b0;
        expect_frame(0, 9'h11, 0, 8, 1'b0, 1'b1, 1'b1);
        s1 = cyc + 1;
        send_frame(0, 9'h11, 8, 0, 1'b0, 1, 1'b1);
        send_frame(0, 9'h22, 8, 0, 1'b0, 1, 1'b1);
        repeat (20) @(negedge clk);
        check_val("overrun_keeps_data", dat_a, 8'h11);
        check_val("overrun_count", ovr_cnt[0], 1);
        check_val("overrun_edge", ovr_edge_a - s1, 10 * C + LAT_8N1);
        rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
        repeat (3) @(negedge clk);

        // Back-to-back with ready exactly on the second completion edge
        expect_frame(0, 9'h11, 0, 8, 1'b0, 1'b1, 1'b1);
        expect_frame(0, 9'h22, 0, 8, 1'b0, 1'b1, 1'b1);
        s1  = cyc + 1;
        tgt = s1 + 10 * C + LAT_8N1;
        fork
            begin
                send_frame(0, 9'h11, 8, 0, 1'b0, 1, 1'b1);
                send_frame(0, 9'h22, 8, 0, 1'b0, 1, 1'b1);
            end
            begin
                while (cyc < tgt - 1) @(negedge clk);
                rdy_a = 1'b1;
                @(negedge clk);
                rdy_a = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        check_val("ready_on_edge_data", dat_a, 8'h22);
        check_val("ready_on_edge_no_ovr", ovr_cnt[0], 1);
        rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;

        // 9O1: hold a frame with a parity error, then reset mid data bit 4
        p = ~par_bit(2, 9'h0AB, 9);
        expect_frame(2, 9'h0AB, 2, 9, p, 1'b1, 1'b1);
        send_frame(2, 9'h0AB, 9, 1, p, 1, 1'b1);
        repeat (5) @(negedge clk);
        check_val("preload_valid_c", vld_c, 1);
        s1  = cyc + 1;
        tgt = s1 + 5 * C + C / 2;
        fork
            send_frame(2, 9'h1F1, 9, 1, par_bit(2, 9'h1F1, 9), 1, 1'b1);
            begin
                while (cyc < tgt - 1) @(negedge clk);
                rst_l = 1'b0;
                @(negedge clk);
                rst_l = 1'b1;
                check_val("midrst_valid_c", vld_c, 0);
                check_val("midrst_data_c", dat_c, 0);
                check_val("midrst_perr_c", pe_c, 0);
                check_val("midrst_ferr_c", fe_c, 0);
                check_val("midrst_break_c", bk_c, 0);
                check_val("midrst_ovr_c", ov_c, 0);
            end
        join
        repeat (20) @(negedge clk);
        check_val("aborted_no_valid_c", vld_c, 0);
        p = par_bit(2, 9'h1FF, 9);
        expect_frame(2, 9'h1FF, 2, 9, p, 1'b1, 1'b1);
        send_frame(2, 9'h1FF, 9, 1, p, 1, 1'b1);
        repeat (5) @(negedge clk);
        check_val("final_valid_c", vld_c, 1);

        check_val("left_in_queue_a", q_a.size(), 0);
        check_val("left_in_queue_b", q_b.size(), 0);
        check_val("left_in_queue_c", q_c.size(), 0);
        check_val("ovr_total_b", ovr_cnt[1], 0);
        check_val("ovr_total_c", ovr_cnt[2], 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver, the successor to the fixed 8N1 receiver. Frame format is set at elaboration: 5–9 data bits, none/even/odd parity, 1 or 2 stop bits. Adds an input synchroniser, parity/framing/break detection, and a one-entry holding register with a valid/ready handshake and overrun reporting. Sits between the serial pin and the byte-consuming logic (command decoder or RX FIFO).

## Interface
- CLKS_PER_BIT, 217, clock cycles per bit; legal ≥ 4
- DATA_BITS, 8, data bits per frame; legal 5..9
- PARITY, 0, 0 none, 1 even, 2 odd
- STOP_BITS, 1, legal 1 or 2

Ports:
- i_Clock  in  1  sole clock
- i_Rst_L  in  1  reset; synchronous and active-low
- i_RX_Serial  in  1  asynchronous serial line, idle high
- o_RX_Valid  out  1  holding register full
- i_RX_Ready  in  1  consumer accepts holding register
- o_RX_Data  out  DATA_BITS  received data, LSB first on the wire
- o_Parity_Err  out  1  parity mismatch; qualified by o_RX_Valid
- o_Frame_Err  out  1  any stop bit sampled 0; qualified by o_RX_Valid
- o_Break  out  1  data, parity and stop all 0; qualified by o_RX_Valid
- o_Overrun  out  1  one-cycle pulse: completed frame dropped

## Operation
- Synchroniser: two flops on i_RX_Serial, both reset to 1. The FSM uses only the second flop (rx_s).
- Bit counter width: $clog2(CLKS_PER_BIT). H = (CLKS_PER_BIT-1)/2, integer division. bit_idx counts data bits.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: counter = 0, bit_idx = 0. If rx_s == 0, go to START.
- START: increment counter until it equals H. At H: if rx_s == 0, clear counter and go to DATA; otherwise (false start) go to IDLE.
- DATA:
  - Count to CLKS_PER_BIT-1, then sample rx_s into shift[bit_idx] and clear the counter.
  - After bit DATA_BITS-1, go to PARITY (PARITY≠0) or STOP.
- PARITY: same wait, sample rx_s.
  - Even: error if XOR(data, pbit) = 1.
  - Odd: error if XOR(data, pbit) = 0.
- STOP: same wait, sample rx_s once per stop bit, mid-bit.
  - Frame_Err = OR of any 0 stop sample.
  - After the last stop sample, the frame is complete; go directly to IDLE with no cleanup state. Back-to-back frames must be received.
- Break = all data bits 0, parity bit 0 (if present), and first stop bit 0. Break implies Frame_Err.
- Frame completion at edge T:
  - If o_RX_Valid == 0, or (o_RX_Valid && i_RX_Ready) at T: load o_RX_Data and the three error flags; o_RX_Valid = 1.
  - Otherwise: drop the new frame, pulse o_Overrun for one cycle, and leave the held contents unchanged.
- Handshake: o_RX_Valid clears on an edge where o_RX_Valid && i_RX_Ready and no frame completes. Data and flags stay stable while valid is high and not accepted.
- Reset (i_Rst_L == 0 at an edge, any state including mid-frame):
  - FSM → IDLE; counters 0; synchroniser 1s.
  - o_RX_Valid = 0, o_RX_Data = 0, o_Parity_Err = 0, o_Frame_Err = 0, o_Break = 0, o_Overrun = 0.
  - A partial frame is discarded. Reception restarts on the next falling edge seen after reset deasserts.

## Timing
- Edge 0 is the first edge at which i_RX_Serial is sampled 0.
- IDLE sees rx_s = 0 at edge 2. Start is confirmed at edge 3+H.
- Data bit k is sampled at edge 3+H+(k+1)·CLKS_PER_BIT.
- Let N = DATA_BITS + (PARITY≠0) + STOP_BITS. The last stop bit is sampled at edge 3+H+N·CLKS_PER_BIT. o_RX_Valid, o_RX_Data and the flags are visible after that edge.
- The earliest next start is detected 1 cycle after completion plus synchroniser delay. Tolerates a transmitter using exactly one stop bit.
- o_Overrun is high for exactly one cycle, the cycle after the dropped frame's completion edge.

## Test plan
- CLKS_PER_BIT=16, 8N1: send 0xA5 with ready held 0.
  - o_RX_Valid rises after edge 154; o_RX_Data = 0xA5; all errors 0.
  - Valid stays high until ready pulses, then clears on that edge.
- 7E2: send 0x35 with correct parity bit 0 → Parity_Err = 0. Resend with parity bit 1 → Parity_Err = 1, o_RX_Data = 0x35.
- 8N1: send 0x3C with stop bit 0 → Frame_Err = 1, Break = 0. Hold the line low for 12 bit times → o_RX_Data = 0x00, Frame_Err = 1, Break = 1.
- Glitch low for 3 cycles (CLKS_PER_BIT=16), then high → no valid, FSM back in IDLE. A subsequent 0x5A frame is received correctly.
- Overrun: two back-to-back frames 0x11, 0x22 with ready = 0 → o_RX_Data stays 0x11 and o_Overrun pulses 1 cycle.
  - Repeat with ready = 1 exactly on the second completion edge → o_RX_Data = 0x22 and no overrun.
- Assert i_Rst_L = 0 for one edge mid-data-bit 4 → all outputs 0, no valid for that frame. A following 9O1 frame 0x1FF is received correctly.
